// File: rtl/uart_tx_arb_ctrl.sv
// rtl/uart_tx_arb_ctrl.sv - two-requester round-robin UART transmit controller
//
// Purpose:
//   Picks one byte at a time from two valid/ready requesters, alternating between
//   them when both are waiting. It then sends the granted byte on tx as a UART
//   frame: start bit, DATA_W data bits LSB first, an optional parity bit, and a
//   stop bit. Each bit lasts OVERSAMPLE pulses of the external baud_tick.
//
// Optional feature macro:
//   UART_TX_PARITY_EN - adds a parity bit between the last data bit and the stop bit.
//                       PARITY_ODD selects odd (1) or even (0) parity.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   baud_tick   in   one-clk pulse at OVERSAMPLE x baud rate
//   req0_valid  in   requester 0 holds a byte
//   req0_data   in   requester 0 byte
//   req0_ready  out  requester 0 byte accepted this cycle (combinational)
//   req1_valid  in   requester 1 holds a byte
//   req1_data   in   requester 1 byte
//   req1_ready  out  requester 1 byte accepted this cycle (combinational)
//   tx          out  serial line, idle high, registered
//   tx_busy     out  frame in progress, registered
//   grant_id    out  source of the current/last frame, registered

module uart_tx_arb_ctrl #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              grant_id
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;

`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`else
  // Odd/even selection has no meaning without the parity bit.
  logic                unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  logic                pick0;
  logic                pick1;
  logic                accept;
  logic                bit_end;
  logic [DATA_W-1:0]   data_sel;

  // Round robin: requester 1 wins when it is alone or when requester 0 had the
  // previous grant; requester 0 wins every other case where it is valid.
  assign pick1   = req1_valid & (~req0_valid | ~last_grant_q);
  assign pick0   = req0_valid & ~pick1;
  assign accept  = (state_q == S_IDLE) & (pick0 | pick1);
  assign data_sel = pick1 ? req1_data : req0_data;

  // Ready depends on rst so nothing is handed over while the block is in reset.
  assign req0_ready = rst & (state_q == S_IDLE) & pick0;
  assign req1_ready = rst & (state_q == S_IDLE) & pick1;

  // A bit ends on the tick that completes OVERSAMPLE ticks in the current bit.
  assign bit_end = baud_tick & (tick_q == TICK_LAST);

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif

    // Ticks are only counted while a frame is in flight; in IDLE they are
    // ignored, so the start bit can be up to one tick period short.
    if (state_q != S_IDLE && baud_tick) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d      = data_sel;
          grant_d      = pick1;
          last_grant_d = pick1;
          tick_d       = '0;
          bit_d        = '0;
          tx_d         = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_START;
`ifdef UART_TX_PARITY_EN
          // Parity is taken from the byte as latched, before any shifting.
          parity_d     = PARITY_ODD ? ~^data_sel : ^data_sel;
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
            bit_d   = bit_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        // Dropping to IDLE here lets the next byte be accepted on the very next
        // edge, so frames can run back to back with tx held high in between.
        if (bit_end) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
      // Starting at 1 gives requester 0 the first grant when both are valid.
      last_grant_q <= 1'b1;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arb_ctrl.sv
// tb/tb_uart_tx_arb_ctrl.sv - directed self-checking bench for uart_tx_arb_ctrl

module tb_uart_tx_arb_ctrl;

  localparam int OS = 8;
  localparam int DW = 8;
  localparam bit PAR_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_tick = 1'b0;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          tx, tx_busy, grant_id;

  int checks = 0;
  int errors = 0;
  int div = 0;

  uart_tx_arb_ctrl #(
    .OVERSAMPLE(OS),
    .DATA_W(DW),
    .PARITY_ODD(PAR_ODD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .baud_tick(baud_tick),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .tx(tx),
    .tx_busy(tx_busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // One baud tick every 4 clocks, changed just after the rising edge.
  always @(posedge clk) begin
    #1;
    baud_tick = (div == 3);
    div = (div + 1) % 4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line levels, index 0 = start bit.
  function automatic logic [10:0] exp_frame(input logic [DW-1:0] d);
    logic [10:0] f;
    f      = '0;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9]   = PAR_ODD ? ~^d : ^d;
    f[10]  = 1'b1;
`else
    f[9]   = 1'b1;
`endif
    return f;
  endfunction

  // Waits for a handshake, then samples tx at every falling edge, indexing by
  // the number of ticks consumed since the accept edge.
  task automatic capture(input bit drop, output logic [10:0] bits, output int ticks,
                         output int gap, output int glitch, output logic gnt);
    int n;
    int guard;
    logic [10:0] seen;
    bits = '0; seen = '0; ticks = -1; gap = 0; glitch = 0; gnt = 1'b0;
    #1;
    guard = 0;
    while (!((req0_ready && req0_valid) || (req1_ready && req1_valid)) && guard < 4000) begin
      @(negedge clk);
      gap++;
      guard++;
    end
    if (guard >= 4000) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    gnt = req1_ready;
    @(posedge clk);
    #1;
    if (drop) begin
      if (gnt) req1_valid = 1'b0;
      else     req0_valid = 1'b0;
    end
    n = 0;
    for (int g = 0; g < 4000; g++) begin
      @(negedge clk);
      if (!tx_busy) begin
        ticks = n;
        break;
      end
      if (n / OS < 11) begin
        if (!seen[n / OS]) begin
          bits[n / OS] = tx;
          seen[n / OS] = 1'b1;
        end else if (bits[n / OS] !== tx) begin
          glitch++;
        end
      end
      if (baud_tick) n++;
    end
    if (ticks < 0) check("frame_timeout", 32'd0, 32'd1);
  endtask

  logic [10:0] bits;
  int ticks, gap, glitch, n;
  logic gnt;
  logic [DW-1:0] c_data [3];
  logic          c_gnt  [3];
  logic [DW-1:0] b_data [3];

  initial begin
    c_data[0] = 8'h11; c_data[1] = 8'h22; c_data[2] = 8'h11;
    c_gnt[0]  = 1'b0;  c_gnt[1]  = 1'b1;  c_gnt[2]  = 1'b0;
    b_data[0] = 8'h3C; b_data[1] = 8'hC3; b_data[2] = 8'h81;

    // Reset with both requesters valid.
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_grant", grant_id, 0);
    rst = 1'b1;

    // Contention: alternate 0x11 / 0x22, requester 0 first.
    for (int i = 0; i < 3; i++) begin
      capture(1'b0, bits, ticks, gap, glitch, gnt);
      check("cont_gnt", gnt, c_gnt[i]);
      check("cont_bits", bits, exp_frame(c_data[i]));
      check("cont_grant_id", grant_id, c_gnt[i]);
      check("cont_glitch", glitch, 0);
      if (i > 0) check("cont_gap", gap, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single byte 0xA5 from requester 0.
    req0_data = 8'hA5;
    req0_valid = 1'b1;
    capture(1'b1, bits, ticks, gap, glitch, gnt);
    check("a5_gnt", gnt, 0);
`ifndef UART_TX_PARITY_EN
    check("a5_bits", bits, 11'h34A);
`else
    check("a5_bits", bits, exp_frame(8'hA5));
`endif
    check("a5_ticks", ticks, OS * NB);
    check("a5_glitch", glitch, 0);

    // Back-to-back frames from requester 1 only.
    req1_data = b_data[0];
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_data = b_data[i];
      capture(1'b0, bits, ticks, gap, glitch, gnt);
      check("b2b_gnt", gnt, 1);
      check("b2b_bits", bits, exp_frame(b_data[i]));
      check("b2b_ticks", ticks, OS * NB);
      check("b2b_glitch", glitch, 0);
      if (i > 0) check("b2b_gap", gap, 0);
    end
    req1_valid = 1'b0;

    // Mid-frame reset during data bit 3 of 0x52 (that bit is 0).
    req0_data = 8'h52;
    req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("mid_accept", req0_ready, 1);
    @(posedge clk);
    n = 0;
    for (int g = 0; g < 4000; g++) begin
      @(negedge clk);
      if (n == OS * 4 + 4) break;
      if (baud_tick) n++;
    end
    check("mid_pre_tx", tx, 0);
    rst = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_ready", req0_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    capture(1'b1, bits, ticks, gap, glitch, gnt);
    check("mid_resend_bits", bits, exp_frame(8'h52));
    check("mid_resend_ticks", ticks, OS * NB);

`ifdef UART_TX_PARITY_EN
    req0_data = 8'h07;
    req0_valid = 1'b1;
    capture(1'b1, bits, ticks, gap, glitch, gnt);
    check("par_bit", bits[9], PAR_ODD ? 1'b0 : 1'b1);
    check("par_ticks", ticks, 88);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
